// File: rtl/ele_pkg.sv
// ============================================================
// ele_pkg : shared state encoding and direction constants
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

package ele_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

`default_nettype wire

// File: rtl/ele_dir_sel.sv
// ============================================================
// ele_dir_sel : SCAN look-ahead, reports requests here/ahead/behind
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

module ele_dir_sel
  import ele_pkg::*;
#(
  parameter int FLOORS = 8,
  parameter int FLR_W  = $clog2(FLOORS)
) (
  input  logic [FLOORS-1:0] pending,
  input  logic [FLR_W-1:0]  curr_flr,
  input  logic              dir_up,
  output logic              here,
  output logic              ahead,
  output logic              behind,
  output logic              next_dir
);

  logic above;
  logic below;

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pending[i] && (FLR_W'(i) > curr_flr)) above = 1'b1;
      if (pending[i] && (FLR_W'(i) < curr_flr)) below = 1'b1;
    end
  end

  assign here   = pending[curr_flr];
  assign ahead  = dir_up ? above : below;
  assign behind = dir_up ? below : above;

  // A reversal at an end floor can only point back into the shaft.
  always_comb begin
    next_dir = dir_up;
    if (!ahead && behind) begin
      if (curr_flr == '0)
        next_dir = DIR_UP;
      else if (curr_flr == FLR_W'(FLOORS - 1))
        next_dir = DIR_DN;
      else
        next_dir = ~dir_up;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ele_scan_ctrl.sv
// ============================================================
// ele_scan_ctrl : N-floor SCAN elevator controller with travel/door timing
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

module ele_scan_ctrl
  import ele_pkg::*;
#(
  parameter int FLOORS     = 8,
  parameter int FLR_W      = $clog2(FLOORS),
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] req,
  output logic [FLR_W-1:0]  curr_flr,
  output logic              moving,
  output logic              dir_up,
  output logic              door_open,
  output logic              arrived,
  output logic [FLOORS-1:0] pending
);

  localparam int TCNT_W = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
  localparam int DCNT_W = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(TRAVEL_CYC - 1);
  // The entry edge already counts as the first travel cycle.
  localparam logic [TCNT_W-1:0] TCNT_ENTRY = TCNT_W'((TRAVEL_CYC > 1) ? 1 : 0);
  localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(DOOR_CYC - 1);

  state_t              state, state_n;
  logic [FLR_W-1:0]    flr_n;
  logic [FLR_W-1:0]    step_flr;
  logic                dir_n;
  logic                arr_n;
  logic [TCNT_W-1:0]   travel_cnt, tcnt_n;
  logic [DCNT_W-1:0]   door_cnt, dcnt_n;
  logic [FLOORS-1:0]   req_eff;
  logic [FLOORS-1:0]   clr;
  logic [FLOORS-1:0]   pend_n;
  logic                here, ahead, behind, next_dir;

  ele_dir_sel #(
    .FLOORS (FLOORS),
    .FLR_W  (FLR_W)
  ) u_dir_sel (
    .pending  (pending),
    .curr_flr (curr_flr),
    .dir_up   (dir_up),
    .here     (here),
    .ahead    (ahead),
    .behind   (behind),
    .next_dir (next_dir)
  );

  assign step_flr = dir_up ? (curr_flr + FLR_W'(1)) : (curr_flr - FLR_W'(1));

  always_comb begin
    state_n = state;
    flr_n   = curr_flr;
    dir_n   = dir_up;
    tcnt_n  = travel_cnt;
    dcnt_n  = door_cnt;
    arr_n   = 1'b0;
    clr     = '0;
    req_eff = req;
    if (state == ST_DOOR) req_eff[curr_flr] = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (here) begin
          state_n = ST_DOOR;
          clr     = FLOORS'(1) << curr_flr;
          arr_n   = 1'b1;
          dcnt_n  = '0;
        end else if (ahead || behind) begin
          state_n = ST_MOVE;
          dir_n   = next_dir;
          tcnt_n  = TCNT_ENTRY;
        end
      end

      ST_MOVE: begin
        if (travel_cnt == TCNT_LAST) begin
          tcnt_n = '0;
          if (!ahead) begin
            state_n = ST_IDLE;
          end else begin
            flr_n = step_flr;
            if (pending[step_flr]) begin
              state_n = ST_DOOR;
              clr     = FLOORS'(1) << step_flr;
              arr_n   = 1'b1;
              dcnt_n  = '0;
            end
          end
        end else begin
          tcnt_n = travel_cnt + TCNT_W'(1);
        end
      end

      ST_DOOR: begin
        if (req[curr_flr]) begin
          dcnt_n = '0;
        end else if (door_cnt == DCNT_LAST) begin
          dcnt_n = '0;
          if (ahead || behind) begin
            state_n = ST_MOVE;
            dir_n   = next_dir;
            tcnt_n  = TCNT_ENTRY;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          dcnt_n = door_cnt + DCNT_W'(1);
        end
      end

      default: state_n = ST_IDLE;
    endcase

    pend_n = (pending | req_eff) & ~clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      curr_flr   <= '0;
      dir_up     <= DIR_UP;
      arrived    <= 1'b0;
      pending    <= '0;
      travel_cnt <= '0;
      door_cnt   <= '0;
    end else begin
      state      <= state_n;
      curr_flr   <= flr_n;
      dir_up     <= dir_n;
      arrived    <= arr_n;
      pending    <= pend_n;
      travel_cnt <= tcnt_n;
      door_cnt   <= dcnt_n;
    end
  end

  assign moving    = (state == ST_MOVE);
  assign door_open = (state == ST_DOOR);

endmodule

`default_nettype wire

// File: tb/tb_ele_scan_ctrl.sv
// ============================================================
// tb_ele_scan_ctrl : directed scenarios plus random requests vs. a reference model
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

module tb_ele_scan_ctrl;

  localparam int FLOORS     = 8;
  localparam int FLR_W      = 3;
  localparam int TRAVEL_CYC = 4;
  localparam int DOOR_CYC   = 3;

  localparam int MD_IDLE = 0;
  localparam int MD_MOVE = 1;
  localparam int MD_DOOR = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [FLOORS-1:0] req = '0;
  logic [FLR_W-1:0]  curr_flr;
  logic              moving, dir_up, door_open, arrived;
  logic [FLOORS-1:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: countdown timers, pending as plain bit vector
  int                m_flr, m_mode, m_left;
  bit                m_up, m_arr;
  bit [FLOORS-1:0]   m_pend;

  ele_scan_ctrl #(
    .FLOORS     (FLOORS),
    .FLR_W      (FLR_W),
    .TRAVEL_CYC (TRAVEL_CYC),
    .DOOR_CYC   (DOOR_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .curr_flr  (curr_flr),
    .moving    (moving),
    .dir_up    (dir_up),
    .door_open (door_open),
    .arrived   (arrived),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_serve();
    m_mode         = MD_DOOR;
    m_left         = DOOR_CYC;
    m_pend[m_flr]  = 1'b0;
    m_arr          = 1'b1;
  endtask

  task automatic m_pick(input int above, input int below);
    int fwd, back;
    fwd  = m_up ? above : below;
    back = m_up ? below : above;
    if (fwd > 0 || back > 0) begin
      if (fwd == 0) m_up = !m_up;
      m_mode = MD_MOVE;
      m_left = (TRAVEL_CYC > 1) ? TRAVEL_CYC - 1 : 1;
    end else begin
      m_mode = MD_IDLE;
    end
  endtask

  task automatic model_edge(input bit [FLOORS-1:0] r, input bit rs);
    bit [FLOORS-1:0] p;
    int above, below;
    p     = m_pend;
    m_arr = 1'b0;
    if (rs) begin
      m_flr = 0; m_up = 1'b1; m_mode = MD_IDLE; m_left = 0; m_pend = '0;
      return;
    end
    above = 0;
    below = 0;
    for (int f = 0; f < FLOORS; f++) begin
      if (p[f] && f > m_flr) above++;
      if (p[f] && f < m_flr) below++;
    end
    m_pend = p | r;
    case (m_mode)
      MD_IDLE: if (p[m_flr]) m_serve(); else m_pick(above, below);
      MD_MOVE: begin
        m_left--;
        if (m_left == 0) begin
          m_flr  = m_up ? m_flr + 1 : m_flr - 1;
          m_left = TRAVEL_CYC;
          if (p[m_flr]) m_serve();
        end
      end
      default: begin
        if (r[m_flr]) begin
          m_pend[m_flr] = p[m_flr];
          m_left        = DOOR_CYC;
        end else begin
          m_left--;
          if (m_left == 0) m_pick(above, below);
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check_eq("curr_flr", 32'(curr_flr), 32'(m_flr));
    check_eq("moving", 32'(moving), 32'(m_mode == MD_MOVE));
    check_eq("dir_up", 32'(dir_up), 32'(m_up));
    check_eq("door_open", 32'(door_open), 32'(m_mode == MD_DOOR));
    check_eq("arrived", 32'(arrived), 32'(m_arr));
    check_eq("pending", 32'(pending), 32'(m_pend));
    check_eq("move_door_excl", 32'(moving && door_open), 0);
  endtask

  task automatic tick(input logic [FLOORS-1:0] r, input logic rs);
    @(negedge clk);
    req = r;
    rst = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
    compare_all();
  endtask

  task automatic settle(input string tag);
    int i;
    for (i = 0; i < 300 && (moving || door_open || pending != '0); i++) tick('0, 1'b0);
    check_eq(tag, 32'(moving || door_open || pending != '0), 0);
  endtask

  initial begin
    int arr_flr[$];
    bit dir_at_1;
    int door_cyc;
    bit seen_arr;
    int i;

    // single up call, edge 0 = reset, edge 1 = request
    tick('0, 1'b1);
    check_eq("rst_flr", 32'(curr_flr), 0);
    check_eq("rst_dir", 32'(dir_up), 1);
    check_eq("rst_pend", 32'(pending), 0);
    tick(8'h08, 1'b0);
    for (int e = 2; e <= 16; e++) begin
      tick('0, 1'b0);
      if (e == 2)  check_eq("up_move_e2", 32'(moving), 1);
      if (e == 5)  check_eq("up_flr_e5", 32'(curr_flr), 1);
      if (e == 9)  check_eq("up_flr_e9", 32'(curr_flr), 2);
      if (e == 13) check_eq("up_flr_e13", 32'(curr_flr), 3);
      if (e == 13) check_eq("up_arr_e13", 32'(arrived), 1);
      if (e == 15) check_eq("up_door_e15", 32'(door_open), 1);
      if (e == 16) check_eq("up_idle_e16", 32'({moving, door_open, pending}), 0);
    end

    // same-floor request at floor 3, then a door extension at door_cnt=2
    tick(8'h08, 1'b0);
    tick('0, 1'b0);
    check_eq("same_arr", 32'(arrived), 1);
    check_eq("same_nomove", 32'({moving, curr_flr}), 32'({1'b0, 3'd3}));
    door_cyc = 1;
    tick('0, 1'b0); door_cyc += door_open;
    tick('0, 1'b0); door_cyc += door_open;
    tick(8'h08, 1'b0); door_cyc += door_open;
    check_eq("same_pend3", 32'(pending[3]), 0);
    for (i = 0; i < 6; i++) begin
      tick('0, 1'b0);
      door_cyc += door_open;
    end
    check_eq("same_door_len", 32'(door_cyc), 6);

    // SCAN ordering: floors 2 and 5, floor 1 requested as the car passes it
    tick('0, 1'b1);
    tick(8'h24, 1'b0);
    seen_arr = 1'b0;
    dir_at_1 = 1'b1;
    for (i = 0; i < 300 && (moving || door_open || pending != '0 || !seen_arr); i++) begin
      tick((curr_flr == 3'd1 && moving && dir_up && !seen_arr) ? 8'h02 : 8'h00, 1'b0);
      if (arrived) begin
        arr_flr.push_back(int'(curr_flr));
        if (curr_flr == 3'd1) dir_at_1 = dir_up;
      end
      if (arrived && curr_flr == 3'd2) seen_arr = 1'b1;
    end
    check_eq("scan_n_stops", 32'(arr_flr.size()), 3);
    if (arr_flr.size() == 3) begin
      check_eq("scan_stop0", 32'(arr_flr[0]), 2);
      check_eq("scan_stop1", 32'(arr_flr[1]), 5);
      check_eq("scan_stop2", 32'(arr_flr[2]), 1);
    end
    check_eq("scan_dir_down", 32'(dir_at_1), 0);

    // boundaries: top floor then bottom floor
    tick('0, 1'b1);
    tick(8'h80, 1'b0);
    settle("tmo_top");
    check_eq("top_flr", 32'(curr_flr), 7);
    tick(8'h01, 1'b0);
    tick('0, 1'b0);
    check_eq("top_rev_dir", 32'(dir_up), 0);
    settle("tmo_bot");
    check_eq("bot_flr", 32'(curr_flr), 0);

    // reset while moving between floors 2 and 3
    tick('0, 1'b1);
    tick(8'h90, 1'b0);
    for (i = 0; i < 100 && !(curr_flr == 3'd2 && moving); i++) tick('0, 1'b0);
    check_eq("tmo_mid", 32'(curr_flr == 3'd2 && moving), 1);
    tick('0, 1'b0);
    tick('0, 1'b1);
    check_eq("midrst_out", 32'({curr_flr, moving, door_open, dir_up}), 32'({3'd0, 1'b0, 1'b0, 1'b1}));
    check_eq("midrst_pend", 32'(pending), 0);

    // idle hold
    for (i = 0; i < 50; i++) begin
      tick('0, 1'b0);
      check_eq("idle_hold", 32'({curr_flr, moving, door_open, arrived, dir_up, pending}), 32'({3'd0, 4'b0001, 8'h00}));
    end

    // random traffic with occasional resets
    for (i = 0; i < 3000; i++) begin
      logic [FLOORS-1:0] r;
      r = '0;
      if ($urandom_range(0, 5) == 0) r = FLOORS'($urandom()) & FLOORS'($urandom());
      tick(r, $urandom_range(0, 499) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
